// File: rtl/time_of_day_counter_pkg.sv
// Shared time-of-day types, BCD digit limits and the load legality check.
package time_of_day_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned HH_W    = 2 * DIGIT_W;
    localparam int unsigned TIME_W  = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] MM_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] MM_TENS_MAX = 4'd5;
    localparam logic [HH_W-1:0]    HH_MAX      = 8'h23;

    typedef struct packed {
        logic [DIGIT_W-1:0] hh_t;
        logic [DIGIT_W-1:0] hh_o;
        logic [DIGIT_W-1:0] mm_t;
        logic [DIGIT_W-1:0] mm_o;
    } bcd_time_t;

    // True when t is a valid 24-hour BCD hh:mm value.
    function automatic logic is_legal_bcd_time(input bcd_time_t t);
        logic [HH_W-1:0] hh;
        hh = {t.hh_t, t.hh_o};
        return (t.hh_t <= 4'd2) && (t.hh_o <= 4'd9) && (hh <= HH_MAX) &&
               (t.mm_t <= MM_TENS_MAX) && (t.mm_o <= MM_ONES_MAX);
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Strobe/load inputs and time/pulse outputs of the time-of-day counter.
interface time_of_day_counter_if;
    import time_of_day_counter_pkg::*;

    logic              one_second;
    logic              one_minute;
    logic              fast_set;
    logic              load_time;
    logic [TIME_W-1:0] load_value;
    logic [TIME_W-1:0] current_time;
    logic              time_changed;
    logic              day_rollover;
    logic              load_error;

    modport master (
        output one_second, one_minute, fast_set, load_time, load_value,
        input  current_time, time_changed, day_rollover, load_error
    );

    modport slave (
        input  one_second, one_minute, fast_set, load_time, load_value,
        output current_time, time_changed, day_rollover, load_error
    );
endinterface

// File: rtl/time_of_day_counter_bcd_digit_counter.sv
// One BCD digit counting 0..MODULUS-1 with load priority and a wrap carry.
module time_of_day_counter_bcd_digit_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int unsigned        MODULUS   = 10,
    parameter logic [DIGIT_W-1:0] RESET_VAL = 4'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_val_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               carry_out_c
);

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit: load beats increment, increment wraps at the modulus.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            digit_d = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= RESET_VAL;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o     = digit_q;
    assign carry_out_c = inc_i & ~load_i & (digit_q == DIGIT_MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD hh:mm time-of-day counter driven by second/minute strobes.
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter logic [HH_W-1:0] RESET_HH = 8'h00,
    parameter logic [HH_W-1:0] RESET_MM = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    time_of_day_counter_if.slave bus
);

    bcd_time_t          load_val_c;
    logic               adv_c;
    logic               load_ok_c;
    logic               inc_c;
    logic               mm_o_carry_c;
    logic               hh_inc_c;
    logic [DIGIT_W-1:0] mm_o;
    logic [DIGIT_W-1:0] mm_t;

    logic [HH_W-1:0]    hh_q;
    logic [HH_W-1:0]    hh_d;
    logic               time_changed_q;
    logic               time_changed_d;
    logic               day_rollover_q;
    logic               day_rollover_d;
    logic               load_error_q;
    logic               load_error_d;

    // Pick the advance strobe; any load request swallows that cycle's advance.
    always_comb begin
        load_val_c = bcd_time_t'(bus.load_value);
        adv_c      = bus.fast_set ? bus.one_second : bus.one_minute;
        load_ok_c  = bus.load_time & is_legal_bcd_time(load_val_c);
        inc_c      = adv_c & ~bus.load_time;
    end

    time_of_day_counter_bcd_digit_counter #(
        .MODULUS   (int'(MM_ONES_MAX) + 1),
        .RESET_VAL (RESET_MM[3:0])
    ) u_mm_ones (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (inc_c),
        .load_i      (load_ok_c),
        .load_val_i  (load_val_c.mm_o),
        .digit_o     (mm_o),
        .carry_out_c (mm_o_carry_c)
    );

    time_of_day_counter_bcd_digit_counter #(
        .MODULUS   (int'(MM_TENS_MAX) + 1),
        .RESET_VAL (RESET_MM[7:4])
    ) u_mm_tens (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (mm_o_carry_c),
        .load_i      (load_ok_c),
        .load_val_i  (load_val_c.mm_t),
        .digit_o     (mm_t),
        .carry_out_c (hh_inc_c)
    );

    // Hours next-state: 09->10, 19->20 via ones wrap, 23->00 as the day wrap.
    always_comb begin
        hh_d = hh_q;
        if (load_ok_c) begin
            hh_d = {load_val_c.hh_t, load_val_c.hh_o};
        end else if (hh_inc_c) begin
            if (hh_q == HH_MAX) begin
                hh_d = 8'h00;
            end else if (hh_q[3:0] == 4'd9) begin
                hh_d = {hh_q[7:4] + 4'd1, 4'd0};
            end else begin
                hh_d = {hh_q[7:4], hh_q[3:0] + 4'd1};
            end
        end
    end

    // Status pulses reflect the event taken on the same edge as the time update.
    always_comb begin
        time_changed_d = load_ok_c | inc_c;
        day_rollover_d = hh_inc_c & (hh_q == HH_MAX);
        load_error_d   = bus.load_time & ~load_ok_c;
    end

    // Hours and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh_q           <= RESET_HH;
            time_changed_q <= 1'b0;
            day_rollover_q <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            hh_q           <= hh_d;
            time_changed_q <= time_changed_d;
            day_rollover_q <= day_rollover_d;
            load_error_q   <= load_error_d;
        end
    end

    assign bus.current_time = {hh_q, mm_t, mm_o};
    assign bus.time_changed = time_changed_q;
    assign bus.day_rollover = day_rollover_q;
    assign bus.load_error   = load_error_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with a minutes-of-day reference model.
module tb_time_of_day_counter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    time_of_day_counter_if bus ();

    time_of_day_counter #(
        .RESET_HH (8'h00),
        .RESET_MM (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time as minutes since midnight.
    int   m_min  = 0;
    logic m_tc   = 1'b0;
    logic m_roll = 1'b0;
    logic m_err  = 1'b0;

    function automatic bit model_legal(input logic [15:0] v);
        int ht, ho, mt, mo;
        ht = int'(v[15:12]); ho = int'(v[11:8]);
        mt = int'(v[7:4]);   mo = int'(v[3:0]);
        return (ht <= 2) && (ho <= 9) && (ht * 10 + ho <= 23) && (mt <= 5) && (mo <= 9);
    endfunction

    function automatic int bcd_to_min(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] min_to_bcd(input int m);
        int h, mm;
        h = m / 60; mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_min  <= 0;
            m_tc   <= 1'b0;
            m_roll <= 1'b0;
            m_err  <= 1'b0;
        end else if (bus.load_time) begin
            m_roll <= 1'b0;
            if (model_legal(bus.load_value)) begin
                m_min <= bcd_to_min(bus.load_value);
                m_tc  <= 1'b1;
                m_err <= 1'b0;
            end else begin
                m_tc  <= 1'b0;
                m_err <= 1'b1;
            end
        end else if (bus.fast_set ? bus.one_second : bus.one_minute) begin
            m_min  <= (m_min + 1) % 1440;
            m_tc   <= 1'b1;
            m_roll <= (m_min == 1439);
            m_err  <= 1'b0;
        end else begin
            m_tc   <= 1'b0;
            m_roll <= 1'b0;
            m_err  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_time", bus.current_time, min_to_bcd(m_min));
        check("model_tc",   16'(bus.time_changed), 16'(m_tc));
        check("model_roll", 16'(bus.day_rollover), 16'(m_roll));
        check("model_err",  16'(bus.load_error),   16'(m_err));
    end

    // Apply one cycle of stimulus; returns at posedge+1 with strobes cleared.
    task automatic cyc(input logic os, input logic om, input logic lt, input logic [15:0] lv);
        bus.one_second = os;
        bus.one_minute = om;
        bus.load_time  = lt;
        bus.load_value = lv;
        @(posedge clk);
        #1;
        bus.one_second = 1'b0;
        bus.one_minute = 1'b0;
        bus.load_time  = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    int tc_count;

    initial begin
        bus.one_second = 1'b0;
        bus.one_minute = 1'b0;
        bus.fast_set   = 1'b0;
        bus.load_time  = 1'b0;
        bus.load_value = 16'h0000;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_time", bus.current_time, 16'h0000);
        check("rst_tc",   16'(bus.time_changed), 16'h0);
        reset = 1'b0;

        // Ten minute strobes, one second strobe ignored in normal mode.
        tc_count = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000);
            if (bus.time_changed) tc_count++;
            if (i == 8) check("nine_min", bus.current_time, 16'h0009);
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            if (bus.time_changed) tc_count++;
        end
        check("ten_min", bus.current_time, 16'h0010);
        check("tc_count", 16'(tc_count), 16'd10);

        // Day rollover.
        cyc(1'b0, 1'b0, 1'b1, 16'h2359);
        check("load_2359", bus.current_time, 16'h2359);
        idle();
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("roll_time", bus.current_time, 16'h0000);
        check("roll_pulse", 16'(bus.day_rollover), 16'h1);
        check("roll_tc", 16'(bus.time_changed), 16'h1);
        idle();
        check("roll_drop", 16'(bus.day_rollover), 16'h0);

        // Illegal loads.
        cyc(1'b0, 1'b0, 1'b1, 16'h2400);
        check("err_2400", 16'(bus.load_error), 16'h1);
        check("err_2400_tc", 16'(bus.time_changed), 16'h0);
        idle();
        cyc(1'b0, 1'b0, 1'b1, 16'h1260);
        check("err_1260", 16'(bus.load_error), 16'h1);
        check("err_time", bus.current_time, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h3000);
        check("err_adv_hold", bus.current_time, 16'h0000);

        // Load beats a simultaneous advance, then fast-set.
        cyc(1'b0, 1'b1, 1'b1, 16'h0815);
        check("load_wins", bus.current_time, 16'h0815);
        bus.fast_set = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        end
        check("fast_set", bus.current_time, 16'h0915);
        bus.fast_set = 1'b0;
        idle();

        // Hour digit carries.
        cyc(1'b0, 1'b0, 1'b1, 16'h1959);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("h19_20", bus.current_time, 16'h2000);
        cyc(1'b0, 1'b0, 1'b1, 16'h0959);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("h09_10", bus.current_time, 16'h1000);
        cyc(1'b0, 1'b0, 1'b1, 16'h1000);
        check("same_load_tc", 16'(bus.time_changed), 16'h1);

        // Async reset right after a load request.
        cyc(1'b0, 1'b0, 1'b1, 16'h1234);
        #1 reset = 1'b1;
        #1;
        check("async_rst_time", bus.current_time, 16'h0000);
        check("async_rst_tc", 16'(bus.time_changed), 16'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        check("post_rst_tc", 16'(bus.time_changed), 16'h0);
        check("post_rst_err", 16'(bus.load_error), 16'h0);

        // Async reset right after an illegal load clears its error pulse.
        cyc(1'b0, 1'b0, 1'b1, 16'h2400);
        #1 reset = 1'b1;
        #1;
        check("async_rst_err", 16'(bus.load_error), 16'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("first_after_rst", bus.current_time, 16'h0001);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
